// File: rtl/stk_pkg.sv
// Shared stack-engine definitions: pointer geometry and allocator state encoding.
package stk_pkg;

    localparam int unsigned PTRS_N = 256;
    localparam int unsigned PTR_W  = $clog2(PTRS_N);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        ALLOC_INIT = 1'b0,
        ALLOC_RUN  = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/rf.sv
// Simple register file: one synchronous write port, one combinational read port.
module rf #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 256,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/stk_ptr_alloc.sv
// Free-list pointer allocator: init sweep fills a circular FIFO of line pointers,
// then serves one alloc (valid/ack) and one free per cycle.
module stk_ptr_alloc #(
    parameter int unsigned PTRS_N = stk_pkg::PTRS_N,
    parameter int unsigned PTR_W  = $clog2(PTRS_N)
) (
    input  logic             clk,
    input  logic             arst,
    output logic             o_busy,
    output logic             o_alloc_vld,
    output logic [PTR_W-1:0] o_alloc_ptr,
    input  logic             i_alloc_ack,
    input  logic             i_free_vld,
    input  logic [PTR_W-1:0] i_free_ptr,
    output logic [PTR_W:0]   o_cnt,
    output logic             o_empty,
    output logic             o_err
);

    import stk_pkg::alloc_state_t;
    import stk_pkg::ALLOC_INIT;
    import stk_pkg::ALLOC_RUN;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(PTRS_N);

    alloc_state_t     state_q, state_d;
    logic [PTR_W-1:0] init_ctr_q, init_ctr_d;
    logic [PTR_W-1:0] rd_idx_q, rd_idx_d;
    logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             alloc_vld;
    logic             alloc_fire;
    logic             free_fire;
    logic             rf_we;
    logic [PTR_W-1:0] rf_waddr;
    logic [PTR_W-1:0] rf_wdata;
    logic [PTR_W-1:0] rf_rdata;

    assign alloc_vld = (state_q == ALLOC_RUN) && (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        init_ctr_d = init_ctr_q;
        rd_idx_d   = rd_idx_q;
        wr_idx_d   = wr_idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        alloc_fire = 1'b0;
        free_fire  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = wr_idx_q;
        rf_wdata   = i_free_ptr;

        case (state_q)
            ALLOC_INIT: begin
                rf_we      = 1'b1;
                rf_waddr   = init_ctr_q;
                rf_wdata   = init_ctr_q;
                init_ctr_d = init_ctr_q + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (i_free_vld || i_alloc_ack) begin
                    err_d = 1'b1;
                end
                // wr_idx wraps onto rd_idx here, so the list is exactly full
                if (init_ctr_q == '1) begin
                    state_d  = ALLOC_RUN;
                    wr_idx_d = '0;
                end
            end
            ALLOC_RUN: begin
                alloc_fire = i_alloc_ack && alloc_vld;
                free_fire  = i_free_vld && ((cnt_q != CNT_FULL) || alloc_fire);
                if (i_alloc_ack && !alloc_vld) begin
                    err_d = 1'b1;
                end
                if (i_free_vld && !free_fire) begin
                    err_d = 1'b1;
                end
                if (alloc_fire) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
                if (free_fire) begin
                    rf_we    = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                end
                case ({free_fire, alloc_fire})
                    2'b10:   cnt_d = cnt_q + 1'b1;
                    2'b01:   cnt_d = cnt_q - 1'b1;
                    default: cnt_d = cnt_q;
                endcase
            end
            default: begin
                state_d = ALLOC_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ALLOC_INIT;
            init_ctr_q <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ctr_q <= init_ctr_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    rf #(
        .W (PTR_W),
        .N (PTRS_N)
    ) u_rf (
        .clk     (clk),
        .i_we    (rf_we),
        .i_waddr (rf_waddr),
        .i_wdata (rf_wdata),
        .i_raddr (rd_idx_q),
        .o_rdata (rf_rdata)
    );

    // Storage is not reset; mask the read so the pointer output is 0 when invalid.
    assign o_alloc_ptr = alloc_vld ? rf_rdata : '0;
    assign o_alloc_vld = alloc_vld;
    assign o_busy      = (state_q == ALLOC_INIT);
    assign o_cnt       = cnt_q;
    assign o_empty     = (cnt_q == '0);
    assign o_err       = err_q;

endmodule

// File: tb/tb_stk_ptr_alloc.sv
// Directed-vector bench for stk_ptr_alloc with an 8-entry pool.
module tb_stk_ptr_alloc;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk;
    logic         arst;
    logic         o_busy;
    logic         o_alloc_vld;
    logic [W-1:0] o_alloc_ptr;
    logic         i_alloc_ack;
    logic         i_free_vld;
    logic [W-1:0] i_free_ptr;
    logic [W:0]   o_cnt;
    logic         o_empty;
    logic         o_err;

    int unsigned n_vec;
    int unsigned n_err;

    stk_ptr_alloc #(
        .PTRS_N (N),
        .PTR_W  (W)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .o_busy      (o_busy),
        .o_alloc_vld (o_alloc_vld),
        .o_alloc_ptr (o_alloc_ptr),
        .i_alloc_ack (i_alloc_ack),
        .i_free_vld  (i_free_vld),
        .i_free_ptr  (i_free_ptr),
        .o_cnt       (o_cnt),
        .o_empty     (o_empty),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"},  32'(o_busy),      1);
        chk({tag, ".vld"},   32'(o_alloc_vld), 0);
        chk({tag, ".ptr"},   32'(o_alloc_ptr), 0);
        chk({tag, ".cnt"},   32'(o_cnt),       0);
        chk({tag, ".empty"}, 32'(o_empty),     1);
        chk({tag, ".err"},   32'(o_err),       0);
    endtask

    // Asynchronous pulse mid-cycle, release on a falling edge; caller is then in cycle 0.
    task automatic pulse_reset(input string tag);
        #2;
        arst = 1'b1;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        arst = 1'b0;
    endtask

    int exp_q[$];
    int exp_ptr;

    initial begin
        n_vec       = 0;
        n_err       = 0;
        arst        = 1'b1;
        i_alloc_ack = 1'b0;
        i_free_vld  = 1'b0;
        i_free_ptr  = '0;

        // Reset and init sweep
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("init.busy", 32'(o_busy), 1);
            if (i == 4) chk("init.cnt4", 32'(o_cnt), 4);
            tick();
        end
        chk("init.done.busy", 32'(o_busy),      0);
        chk("init.done.cnt",  32'(o_cnt),       8);
        chk("init.done.vld",  32'(o_alloc_vld), 1);
        chk("init.done.ptr",  32'(o_alloc_ptr), 0);

        // Drain the pool in order
        for (int i = 0; i < 8; i++) begin
            chk("drain.vld", 32'(o_alloc_vld), 1);
            chk("drain.ptr", 32'(o_alloc_ptr), 32'(i));
            i_alloc_ack = 1'b1;
            tick();
        end
        i_alloc_ack = 1'b0;
        chk("drain.end.vld",   32'(o_alloc_vld), 0);
        chk("drain.end.empty", 32'(o_empty),     1);
        chk("drain.end.cnt",   32'(o_cnt),       0);

        // Free into an empty pool: visible next cycle, no bypass
        i_free_vld = 1'b1;
        i_free_ptr = 3'd5;
        chk("free5.nobypass", 32'(o_alloc_vld), 0);
        tick();
        i_free_vld = 1'b0;
        chk("free5.vld", 32'(o_alloc_vld), 1);
        chk("free5.ptr", 32'(o_alloc_ptr), 5);
        chk("free5.cnt", 32'(o_cnt),       1);

        // Bring count to 3, then steady-state alloc+free of 6 across the wrap
        i_free_vld = 1'b1;
        i_free_ptr = 3'd1;
        tick();
        i_free_ptr = 3'd2;
        tick();
        i_free_vld = 1'b0;
        chk("fill3.cnt", 32'(o_cnt), 3);
        exp_q = '{5, 1, 2};
        for (int i = 0; i < 10; i++) begin
            exp_ptr = exp_q.pop_front();
            chk("steady.ptr", 32'(o_alloc_ptr), 32'(exp_ptr));
            chk("steady.cnt", 32'(o_cnt),       3);
            exp_q.push_back(6);
            i_alloc_ack = 1'b1;
            i_free_vld  = 1'b1;
            i_free_ptr  = 3'd6;
            tick();
        end
        i_alloc_ack = 1'b0;
        i_free_vld  = 1'b0;
        chk("steady.end.cnt", 32'(o_cnt), 3);
        chk("steady.end.err", 32'(o_err), 0);

        // Drain the three 6s, then ack with nothing valid
        for (int i = 0; i < 3; i++) begin
            chk("drain6.ptr", 32'(o_alloc_ptr), 6);
            i_alloc_ack = 1'b1;
            tick();
        end
        chk("ackempty.pre.err", 32'(o_err), 0);
        tick();
        i_alloc_ack = 1'b0;
        chk("ackempty.err", 32'(o_err), 1);
        chk("ackempty.cnt", 32'(o_cnt), 0);
        tick();
        tick();
        chk("ackempty.sticky", 32'(o_err), 1);

        // Free during INIT is ignored but flagged
        pulse_reset("rst2");
        i_free_vld = 1'b1;
        i_free_ptr = 3'd3;
        tick();
        i_free_vld = 1'b0;
        chk("initfree.err",  32'(o_err),  1);
        chk("initfree.busy", 32'(o_busy), 1);
        for (int i = 0; i < 7; i++) tick();
        chk("initfree.busy0", 32'(o_busy),      0);
        chk("initfree.cnt",   32'(o_cnt),       8);
        chk("initfree.ptr",   32'(o_alloc_ptr), 0);
        chk("initfree.sticky", 32'(o_err),      1);

        // Free into a full pool without an alloc is dropped
        pulse_reset("rst3");
        for (int i = 0; i < 8; i++) tick();
        chk("full.pre.cnt", 32'(o_cnt), 8);
        chk("full.pre.err", 32'(o_err), 0);
        i_free_vld = 1'b1;
        i_free_ptr = 3'd7;
        tick();
        i_free_vld = 1'b0;
        chk("full.err", 32'(o_err), 1);
        chk("full.cnt", 32'(o_cnt), 8);
        chk("full.ptr", 32'(o_alloc_ptr), 0);

        // Allocate down to 2, then reset mid-operation
        for (int i = 0; i < 6; i++) begin
            i_alloc_ack = 1'b1;
            tick();
        end
        i_alloc_ack = 1'b0;
        chk("mid.cnt",    32'(o_cnt),       2);
        chk("mid.ptr",    32'(o_alloc_ptr), 6);
        chk("mid.sticky", 32'(o_err),       1);
        pulse_reset("rst4");
        for (int i = 0; i < 8; i++) tick();
        chk("reinit.busy", 32'(o_busy),      0);
        chk("reinit.cnt",  32'(o_cnt),       8);
        chk("reinit.ptr",  32'(o_alloc_ptr), 0);
        chk("reinit.err",  32'(o_err),       0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stk_ptr_alloc.md
# stk_ptr_alloc

Free-list pointer allocator for the stack engine. It owns the pool of data/link SRAM line pointers, hands one pointer per cycle to the LK stage for PUSH commands, and takes freed pointers back from POP/INV retirement. After reset it sequences an initialisation sweep that fills the free list, then arbitrates one allocation and one free per cycle. It sits beside the stack pipe and drives the allocation pointer input of the LK stage.

## Interface
- PTRS_N, default 256: number of managed pointers; power of two, at least 4.
- PTR_W, default $clog2(PTRS_N): pointer width; must equal stk_pkg::PTR_W.
- clk  in  1  clock; all state changes on the rising edge.
- arst  in  1  reset; asynchronous assertion and deassertion, active-high.
- o_busy  out  1  initialisation sweep in progress.
- o_alloc_vld  out  1  a free pointer is available on o_alloc_ptr.
- o_alloc_ptr  out  PTR_W  head of the free list.
- i_alloc_ack  in  1  the LK stage consumed o_alloc_ptr this cycle.
- i_free_vld  in  1  return the pointer on i_free_ptr.
- i_free_ptr  in  PTR_W  pointer being returned.
- o_cnt  out  PTR_W+1  number of free pointers held.
- o_empty  out  1  o_cnt == 0.
- o_err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- The free list is a circular FIFO with PTRS_N entries of PTR_W bits.
- It keeps a read index rd_idx, a write index wr_idx, and a count cnt.
- rd_idx and wr_idx are PTR_W bits wide and wrap naturally from PTRS_N-1 to 0.
- cnt is PTR_W+1 bits wide.
- FSM has two states, INIT and RUN.
- Reset enters INIT with init_ctr=0, rd_idx=0, wr_idx=0, cnt=0, o_err=0.
- INIT:
  - Each cycle writes the value init_ctr into entry init_ctr, then increments init_ctr and cnt.
  - After the write with init_ctr == PTRS_N-1, the FSM moves to RUN and sets wr_idx=0.
  - wr_idx wraps, so the list is full at that point.
- RUN:
  - o_alloc_vld = (cnt != 0).
  - o_alloc_ptr = entry[rd_idx]. This is a combinational read of the FIFO storage.
  - Alloc: when i_alloc_ack is high and o_alloc_vld is high, rd_idx increments and cnt decrements.
  - Free: when i_free_vld is high, i_free_ptr is written to entry[wr_idx], wr_idx increments and cnt increments.
  - Alloc and free in the same cycle: both indices advance and cnt is unchanged.
  - When empty, a free is not bypassed. The freed pointer appears on o_alloc_ptr the following cycle.
- Errors set o_err and leave the state unchanged:
  - i_alloc_ack while o_alloc_vld is 0; the ack is ignored.
  - i_free_vld while cnt == PTRS_N and there is no same-cycle alloc; the free is dropped.
  - i_free_vld or i_alloc_ack during INIT; the request is ignored.
- Duplicate-pointer detection is out of scope.

## Timing
- Reset values of all outputs:
  - o_busy=1, o_alloc_vld=0, o_alloc_ptr=0 (don't-care while o_alloc_vld=0), o_cnt=0, o_empty=1, o_err=0.
- Initialisation takes PTRS_N cycles after arst deasserts.
- On cycle PTRS_N the outputs are o_busy=0, o_alloc_vld=1, o_alloc_ptr=0 and o_cnt=PTRS_N.
- Allocation uses a valid/ack handshake with zero latency.
  - The ack is combinational against o_alloc_vld in the same cycle.
  - The next pointer is presented on the following cycle.
- Sustained throughput is one alloc plus one free per cycle.
- o_cnt, o_empty and o_err are registered, or derived only from registered state.
- Asserting arst mid-operation immediately forces the reset values and restarts INIT; FIFO contents are discarded.
- Allocation order is FIFO: pointers come out in the order they were freed.

## Structure
- PTR_W and ptr_t belong in stk_pkg; this block must not redefine them.
- Add PTRS_N to stk_pkg as a localparam.
- Add the state encoding to stk_pkg as a typedef alloc_state_t {ALLOC_INIT, ALLOC_RUN}.
- The storage is a single sub-module instance of rf, with W=PTR_W and N=PTRS_N.
  - Its write port is muxed between the init sweep and the free path.
  - Its read address is rd_idx.
- The FSM, counters and error logic live in this module.

## Test plan
- Reset with PTRS_N=8, then idle:
  - o_busy=1 for cycles 0..7.
  - Cycle 8: o_busy=0, o_cnt=8, o_alloc_vld=1, o_alloc_ptr=0.
- Ack 8 consecutive cycles after init:
  - o_alloc_ptr is 0,1,...,7 in order.
  - Then o_alloc_vld=0, o_empty=1, o_cnt=0.
- Pool empty, free ptr 5:
  - On the next cycle o_alloc_vld=1, o_alloc_ptr=5, o_cnt=1.
- Pool at cnt=3, then simultaneous ack and free of ptr 6 for 10 cycles:
  - o_cnt stays 3.
  - Freed 6s emerge in FIFO order after the 3 resident pointers.
  - Indices wrap correctly.
- Error cases, each setting o_err=1:
  - Ack with o_alloc_vld=0.
  - Free with o_cnt=8 and no ack; o_cnt stays 8.
  - Free during INIT; after init, o_cnt=8.
  - In every case o_err stays 1 until arst.
- Assert arst when o_cnt=2 in RUN:
  - All outputs return to reset values that same cycle.
  - Init re-runs, and 8 cycles after deassertion o_cnt=8 and o_alloc_ptr=0.
